// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage: radix-2 shift-add multiply,
// restoring divide, with a one-cycle fast path for divide-by-zero and signed overflow.
module ex_muldiv_seq #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iStart,
    input  logic [2:0]            iFunc3,
    input  logic [XLEN-1:0]       iA,
    input  logic [XLEN-1:0]       iB,
    input  logic [REG_ADDR_W-1:0] iRdAddr,
    input  logic                  iFlush,
    input  logic                  iHold,
    output logic                  oStall,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [XLEN-1:0]       oResult,
    output logic [REG_ADDR_W-1:0] oRdAddr
);

    localparam int unsigned CntW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} stateT;

    stateT              state;
    logic [CntW-1:0]    cnt;
    logic [2:0]         func3;
    logic               sign;
    logic [XLEN-1:0]    mcand;   // multiplicand magnitude, or divisor magnitude
    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    quot;
    logic [XLEN-1:0]    rem;

    logic               isDivIn, signedA, signedB, signA, signB, bZero, overflow, fastPath;
    logic               startSign;
    logic [XLEN-1:0]    magA, magB, fastResult;

    logic [XLEN:0]      addSum, shifted, trial;
    logic [2*XLEN-1:0]  prodNext, prodFix;
    logic [XLEN-1:0]    quotFix, remFix, fixResult;

    assign oStall = iStart & (state != StDone);

    // Operand decode for the accept cycle
    always_comb begin
        isDivIn    = iFunc3[2];
        signedA    = (iFunc3 == 3'd1) || (iFunc3 == 3'd2) || (iFunc3 == 3'd4) || (iFunc3 == 3'd6);
        signedB    = (iFunc3 == 3'd1) || (iFunc3 == 3'd4) || (iFunc3 == 3'd6);
        signA      = signedA & iA[XLEN-1];
        signB      = signedB & iB[XLEN-1];
        magA       = signA ? -iA : iA;
        magB       = signB ? -iB : iB;
        bZero      = (iB == '0);
        overflow   = isDivIn && !iFunc3[0] && (iA == MinInt) && (&iB);
        fastPath   = isDivIn && (bZero || overflow);
        startSign  = (isDivIn && iFunc3[1]) ? signA : (signA ^ signB);
        fastResult = '0;
        if (bZero) fastResult = iFunc3[1] ? iA : '1;
        else       fastResult = iFunc3[1] ? '0 : MinInt;
    end

    // One iteration of each datapath plus the final sign fixup
    always_comb begin
        addSum    = prod[0] ? ({1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, mcand})
                            : {1'b0, prod[2*XLEN-1:XLEN]};
        prodNext  = {addSum, prod[XLEN-1:1]};
        shifted   = {rem, quot[XLEN-1]};
        trial     = shifted - {1'b0, mcand};
        prodFix   = sign ? -prod : prod;
        quotFix   = sign ? -quot : quot;
        remFix    = sign ? -rem : rem;
        fixResult = '0;
        if (func3[2])            fixResult = func3[1] ? remFix : quotFix;
        else if (func3 == 3'd0)  fixResult = prodFix[XLEN-1:0];
        else                     fixResult = prodFix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state   <= StIdle;
            cnt     <= '0;
            func3   <= '0;
            sign    <= 1'b0;
            mcand   <= '0;
            prod    <= '0;
            quot    <= '0;
            rem     <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oResult <= '0;
            oRdAddr <= '0;
        end else if (iFlush) begin
            state <= StIdle;
            cnt   <= '0;
            oBusy <= 1'b0;
            oDone <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (iStart) begin
                        func3   <= iFunc3;
                        oRdAddr <= iRdAddr;
                        sign    <= startSign;
                        cnt     <= '0;
                        oBusy   <= 1'b1;
                        if (isDivIn) begin
                            mcand <= magB;
                            quot  <= magA;
                            rem   <= '0;
                        end else begin
                            mcand <= magA;
                            prod  <= {{XLEN{1'b0}}, magB};
                        end
                        if (fastPath) begin
                            oResult <= fastResult;
                            oDone   <= 1'b1;
                            state   <= StDone;
                        end else begin
                            state <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    cnt <= cnt + 1'b1;
                    if (func3[2]) begin
                        if (!trial[XLEN]) begin
                            rem  <= trial[XLEN-1:0];
                            quot <= {quot[XLEN-2:0], 1'b1};
                        end else begin
                            rem  <= shifted[XLEN-1:0];
                            quot <= {quot[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        prod <= prodNext;
                    end
                    if (cnt == CntW'(XLEN-1)) state <= StFixup;
                end
                StFixup: begin
                    oResult <= fixResult;
                    oDone   <= 1'b1;
                    state   <= StDone;
                end
                StDone: begin
                    if (!iHold) begin
                        oDone <= 1'b0;
                        oBusy <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: per-feature tasks with hand-computed expected values.
module tb_ex_muldiv_seq;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iStart = 1'b0;
    logic [2:0]  iFunc3 = '0;
    logic [31:0] iA = '0;
    logic [31:0] iB = '0;
    logic [4:0]  iRdAddr = '0;
    logic        iFlush = 1'b0;
    logic        iHold = 1'b0;
    logic        oStall, oBusy, oDone;
    logic [31:0] oResult;
    logic [4:0]  oRdAddr;

    int vectors = 0;
    int miscompares = 0;
    int cycleCount = 0;

    ex_muldiv_seq #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iFunc3(iFunc3), .iA(iA), .iB(iB),
        .iRdAddr(iRdAddr), .iFlush(iFlush), .iHold(iHold), .oStall(oStall), .oBusy(oBusy),
        .oDone(oDone), .oResult(oResult), .oRdAddr(oRdAddr)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) cycleCount <= cycleCount + 1;

    // Present an op at the start of a fresh cycle (cycle 0 of the op)
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(posedge iClk);
        #1;
        iFunc3 = f; iA = a; iB = b; iRdAddr = rd; iStart = 1'b1;
    endtask

    // Bounded wait for oDone; returns the done cycle index and number of stall cycles before it
    task automatic waitDone(output int cyc, output int stalls, output int stamp);
        bit found = 0;
        cyc = 0; stalls = 0; stamp = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge iClk);
            if (oDone) begin
                found = 1;
                stamp = cycleCount;
            end else begin
                if (oStall) stalls++;
                cyc++;
            end
        end
    endtask

    task automatic retire();
        @(posedge iClk);
        #1;
        iStart = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (oDone !== 1'b0 || oBusy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: done=%b busy=%b, required 0 0", oDone, oBusy);
        end
        vectors++;
        if (oResult !== 32'h0 || oRdAddr !== 5'h0) begin
            miscompares++;
            $display("FAIL reset_data: result=%h rd=%h, required 0 0", oResult, oRdAddr);
        end
        vectors++;
        if (oStall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall: stall=%b, required 0", oStall);
        end
        @(posedge iClk);
        #1;
        iRst = 1'b0;
    endtask

    task automatic test_mul();
        int cyc, stalls, stamp;
        issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
        waitDone(cyc, stalls, stamp);
        vectors++;
        if (cyc !== 34) begin
            miscompares++;
            $display("FAIL mul_latency: got %0d cycles, required 34", cyc);
        end
        vectors++;
        if (stalls !== 34) begin
            miscompares++;
            $display("FAIL mul_stall_cycles: got %0d, required 34", stalls);
        end
        vectors++;
        if (oResult !== 32'hFFFFFFEB) begin
            miscompares++;
            $display("FAIL mul_result: got %h, required ffffffeb", oResult);
        end
        vectors++;
        if (oRdAddr !== 5'd5) begin
            miscompares++;
            $display("FAIL mul_rd: got %0d, required 5", oRdAddr);
        end
        vectors++;
        if (oStall !== 1'b0 || oBusy !== 1'b1) begin
            miscompares++;
            $display("FAIL mul_done_flags: stall=%b busy=%b, required 0 1", oStall, oBusy);
        end
        retire();
        @(negedge iClk);
        vectors++;
        if (oDone !== 1'b0 || oBusy !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_idle_after: done=%b busy=%b, required 0 0", oDone, oBusy);
        end
    endtask

    task automatic test_mulh();
        logic [2:0]  f [3];
        logic [31:0] a [3];
        logic [31:0] b [3];
        logic [31:0] e [3];
        int cyc, stalls, stamp;
        f[0] = 3'd3; a[0] = 32'hFFFFFFFF; b[0] = 32'hFFFFFFFF; e[0] = 32'hFFFFFFFE;
        f[1] = 3'd1; a[1] = 32'hFFFFFFFF; b[1] = 32'hFFFFFFFF; e[1] = 32'h00000000;
        f[2] = 3'd2; a[2] = 32'hFFFFFFFF; b[2] = 32'd2;        e[2] = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            issue(f[i], a[i], b[i], 5'(i + 1));
            waitDone(cyc, stalls, stamp);
            vectors++;
            if (cyc !== 34 || oResult !== e[i]) begin
                miscompares++;
                $display("FAIL mulh_%0d: got %h at cycle %0d, required %h at cycle 34",
                         f[i], oResult, cyc, e[i]);
            end
            retire();
        end
    endtask

    task automatic test_div();
        logic [2:0]  f [4];
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [31:0] e [4];
        int cyc, stalls, stamp;
        f[0] = 3'd4; a[0] = 32'hFFFFFFF9; b[0] = 32'd2; e[0] = 32'hFFFFFFFD;
        f[1] = 3'd6; a[1] = 32'hFFFFFFF9; b[1] = 32'd2; e[1] = 32'hFFFFFFFF;
        f[2] = 3'd5; a[2] = 32'd100;      b[2] = 32'd7; e[2] = 32'd14;
        f[3] = 3'd7; a[3] = 32'd100;      b[3] = 32'd7; e[3] = 32'd2;
        for (int i = 0; i < 4; i++) begin
            issue(f[i], a[i], b[i], 5'(i + 10));
            waitDone(cyc, stalls, stamp);
            vectors++;
            if (cyc !== 34 || oResult !== e[i]) begin
                miscompares++;
                $display("FAIL div_%0d: got %h at cycle %0d, required %h at cycle 34",
                         f[i], oResult, cyc, e[i]);
            end
            retire();
        end
    endtask

    task automatic test_fast_path();
        logic [2:0]  f [4];
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [31:0] e [4];
        int cyc, stalls, stamp;
        f[0] = 3'd4; a[0] = 32'd5;        b[0] = 32'd0;        e[0] = 32'hFFFFFFFF;
        f[1] = 3'd6; a[1] = 32'd5;        b[1] = 32'd0;        e[1] = 32'd5;
        f[2] = 3'd4; a[2] = 32'h80000000; b[2] = 32'hFFFFFFFF; e[2] = 32'h80000000;
        f[3] = 3'd6; a[3] = 32'h80000000; b[3] = 32'hFFFFFFFF; e[3] = 32'h00000000;
        for (int i = 0; i < 4; i++) begin
            issue(f[i], a[i], b[i], 5'(i + 20));
            waitDone(cyc, stalls, stamp);
            vectors++;
            if (cyc !== 1 || stalls !== 1 || oResult !== e[i]) begin
                miscompares++;
                $display("FAIL fast_%0d: got %h at cycle %0d stalls %0d, required %h at 1 stalls 1",
                         i, oResult, cyc, stalls, e[i]);
            end
            retire();
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        issue(3'd5, 32'd100, 32'd7, 5'd3);
        repeat (10) @(posedge iClk);
        #1;
        vectors++;
        if (oBusy !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_busy_before: busy=%b, required 1", oBusy);
        end
        iFlush = 1'b1;
        iStart = 1'b0;
        @(posedge iClk);
        #1;
        iFlush = 1'b0;
        vectors++;
        if (oBusy !== 1'b0 || oDone !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle: busy=%b done=%b, required 0 0", oBusy, oDone);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge iClk);
            if (oDone) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL flush_no_done: done seen %0d cycles, required 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        issue(3'd0, 32'd3, 32'd4, 5'd9);
        repeat (20) @(posedge iClk);
        #1;
        iRst = 1'b1;
        iStart = 1'b0;
        #1;
        vectors++;
        if ({oDone, oBusy, oResult, oRdAddr} !== 39'h0 || oStall !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: done=%b busy=%b result=%h rd=%h stall=%b, required all 0",
                     oDone, oBusy, oResult, oRdAddr, oStall);
        end
        #4;
        iRst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge iClk);
            if (oDone) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL rst_mid_no_done: done seen %0d cycles, required 0", seen);
        end
    endtask

    task automatic test_hold();
        int cyc, stalls, stamp;
        issue(3'd0, 32'd6, 32'd7, 5'd12);
        waitDone(cyc, stalls, stamp);
        iHold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            vectors++;
            if (oDone !== 1'b1 || oResult !== 32'd42) begin
                miscompares++;
                $display("FAIL hold_%0d: done=%b result=%h, required 1 0000002a", i, oDone, oResult);
            end
        end
        iHold = 1'b0;
        retire();
        @(negedge iClk);
        vectors++;
        if (oDone !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release: done=%b, required 0", oDone);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, stalls, stamp1, stamp2;
        logic [31:0] r1;
        issue(3'd0, 32'd3, 32'd5, 5'd7);
        waitDone(cyc, stalls, stamp1);
        r1 = oResult;
        @(posedge iClk);
        #1;
        iA = 32'h00010001; iB = 32'h00010000; iRdAddr = 5'd8;
        waitDone(cyc, stalls, stamp2);
        vectors++;
        if (r1 !== 32'd15 || oResult !== 32'h00010000 || oRdAddr !== 5'd8) begin
            miscompares++;
            $display("FAIL b2b_results: got %h %h rd %0d, required 0000000f 00010000 rd 8",
                     r1, oResult, oRdAddr);
        end
        vectors++;
        if (stamp2 - stamp1 !== 35) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d cycles, required 35", stamp2 - stamp1);
        end
        retire();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_fast_path();
        test_flush();
        test_reset_mid();
        test_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
